// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - instruction buffer between fetch and decode stages
module if_id_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_ifu_valid_i,
    input  logic [31:0]                pc_ifu_i,
    input  logic [31:0]                inst_data_ifu_i,
    output logic                       ifu_ready_o,
    input  logic                       id_ready_i,
    input  logic                       hold_flag_i,
    input  logic                       flush_i,
    output logic                       inst_id_valid_o,
    output logic [31:0]                pc_id_o,
    output logic [31:0]                inst_data_id_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          empty;
    logic          push;
    logic          pop;

    // Handshake qualifiers; a flush masks both sides so nothing moves that cycle
    always_comb begin
        empty           = (count_q == '0);
        ifu_ready_o     = (count_q < FULL_COUNT) && !flush_i;
        inst_id_valid_o = !empty && !hold_flag_i && !flush_i;
        push            = inst_ifu_valid_i && ifu_ready_o;
        pop             = inst_id_valid_o && id_ready_i;
    end

    // Head entry toward decode; an empty buffer presents a harmless NOP
    always_comb begin
        pc_id_o        = 32'h0;
        inst_data_id_o = NOP_INST;
        if (!empty) begin
            pc_id_o        = pc_mem_q[rd_ptr_q];
            inst_data_id_o = inst_mem_q[rd_ptr_q];
        end
    end

    // Next pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset discards all entries and overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are left as-is on reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_ifu_i;
            inst_mem_q[wr_ptr_q] <= inst_data_ifu_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - scoreboard bench for if_id_buf with directed and random traffic
module tb_if_id_buf;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        ifu_ready;
    logic        id_ready;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    logic [63:0] exp_q [$];

    if_id_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_ifu_valid_i (valid_i),
        .pc_ifu_i         (pc_i),
        .inst_data_ifu_i  (inst_i),
        .ifu_ready_o      (ifu_ready),
        .id_ready_i       (id_ready),
        .hold_flag_i      (hold),
        .flush_i          (flush),
        .inst_id_valid_o  (id_valid),
        .pc_id_o          (pc_id),
        .inst_data_id_o   (inst_id),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a plain FIFO of accepted {pc,inst} pairs
    always @(posedge clk) begin
        int sz;
        bit do_push;
        bit do_pop;
        sz = exp_q.size();
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            do_push = valid_i && (sz < DEPTH);
            do_pop  = (sz != 0) && !hold && id_ready;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({pc_i, inst_i});
        end
    end

    // Monitor: compare everything the DUT presents against the model mid-cycle
    always @(negedge clk) begin
        int sz;
        if (mon_en) begin
            sz = exp_q.size();
            chk("count", 32'(count), 32'(sz));
            chk("ifu_ready", 32'(ifu_ready), 32'((sz < DEPTH) && !flush));
            chk("id_valid", 32'(id_valid), 32'((sz != 0) && !hold && !flush));
            if (sz != 0) begin
                chk("head_pc", pc_id, exp_q[0][63:32]);
                chk("head_inst", inst_id, exp_q[0][31:0]);
            end else begin
                chk("empty_pc", pc_id, 32'h0);
                chk("empty_inst", inst_id, NOP);
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input bit hd, input bit fl, input bit rs);
        valid_i  = v;
        pc_i     = pc;
        inst_i   = ins;
        id_ready = rdy;
        hold     = hd;
        flush    = fl;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] pc_r;
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Three pushes with decode stalled
        for (int i = 0; i < 3; i++)
            cyc(1, 32'(i * 4), 32'h0010_0093 + 32'(i) * 32'h0010_0080, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Fill to full with valid held high, then a single pop
        do_reset();
        for (int i = 0; i < 5; i++)
            cyc(1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 0, 0, 0);
        cyc(1, 32'h200, 32'hBEEF_0000, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Streaming with decode always ready, across pointer wraps
        do_reset();
        for (int i = 0; i < 10; i++)
            cyc(1, 32'(i * 4), 32'hC000_0000 + 32'(i), 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Hold freezes issue while a push still lands
        do_reset();
        cyc(1, 32'h10, 32'hD000_0001, 0, 0, 0, 0);
        cyc(1, 32'h14, 32'hD000_0002, 0, 0, 0, 0);
        cyc(1, 32'h18, 32'hD000_0003, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Flush with a simultaneous push
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 32'h20 + 32'(i * 4), 32'hE000_0000 + 32'(i), 0, 0, 0, 0);
        cyc(1, 32'h40, 32'hE000_0040, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);

        // Reset mid-operation with push and pop active
        cyc(1, 32'h50, 32'hF000_0001, 0, 0, 0, 0);
        cyc(1, 32'h54, 32'hF000_0002, 0, 0, 0, 0);
        cyc(1, 32'h58, 32'hF000_0003, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        pc_r = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            bit v, r, h, f, s;
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < 55);
            h = ($urandom_range(0, 99) < 15);
            f = ($urandom_range(0, 99) < 3);
            s = ($urandom_range(0, 199) < 1);
            cyc(v, pc_r, $urandom, r, h, f, s);
            if (v) pc_r = pc_r + 32'h4;
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
